// File: rtl/mse_pkg.sv
// mse_pkg: width helpers and the result-entry type shared by
// the windowed mean-square-error engine and its result FIFO.
package mse_pkg;

  // Widest fields a result entry can carry: up to 65536
  // channels and DATA_W up to 32.
  localparam int MAX_CH_W = 16;
  localparam int MAX_SQ_W = 63;

  function automatic int ch_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int sq_w(input int data_w);
    return 2 * data_w - 1;
  endfunction

  function automatic int acc_w(
    input int data_w,
    input int win_log2
  );
    return 2 * data_w - 1 + win_log2;
  endfunction

  typedef struct packed {
    logic [MAX_CH_W-1:0] ch;
    logic [MAX_SQ_W-1:0] mse;
    logic [MAX_SQ_W-1:0] peak;
  } mse_res_t;

endpackage

// File: rtl/mse_result_fifo.sv
// mse_result_fifo: synchronous FIFO for window results.
// Ports: clk, reset (sync, active-high); push/push_data write
// side; pop/head read side (head reads 0 while empty);
// empty, full and free (free-slot count) status.
module mse_result_fifo
  import mse_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   free
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(
    input logic [PTR_W-1:0] p
  );
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign free    = CNT_W'(DEPTH) - count;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head is masked while empty so the outputs read zero after
  // reset without clearing the storage array.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mse_window_accum.sv
// mse_window_accum: per-channel windowed mean-square-error engine.
// Squares signed error samples (S1), accumulates each channel over
// 2^WIN_LOG2 samples (S2) and pushes {ch, mse, peak} to a FIFO.
// Ports: clk, reset (sync, active-high), clear; in_valid/in_ready/
// in_ch/in_err sample input; out_valid/out_ready/out_ch/out_mse/
// out_peak result output.
// Build option: define MSE_PEAK_EN to track the per-window peak
// square; otherwise out_peak is tied to 0.
module mse_window_accum
  import mse_pkg::*;
#(
  parameter  int DATA_W    = 18,
  parameter  int NCH       = 4,
  parameter  int WIN_LOG2  = 10,
  parameter  int RES_DEPTH = 4,
  localparam int CH_W      = ch_w(NCH),
  localparam int SQ_W      = sq_w(DATA_W),
  localparam int ACC_W     = acc_w(DATA_W, WIN_LOG2)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_err,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [SQ_W-1:0]          out_mse,
  output logic [SQ_W-1:0]          out_peak
);

  localparam int CNT_W  = (WIN_LOG2 > 0) ? WIN_LOG2 : 1;
  localparam int FREE_W = $clog2(RES_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((64'd1 << WIN_LOG2) - 64'd1);
`ifdef MSE_PEAK_EN
  localparam int E_W = CH_W + 2 * SQ_W;
`else
  localparam int E_W = CH_W + SQ_W;
`endif

  logic                     accept;
  logic                     ch_ok;
  logic signed [2*DATA_W-1:0] prod;

  logic                     s1_valid;
  logic [CH_W-1:0]          s1_ch;
  logic [SQ_W-1:0]          s1_sq;

  logic [ACC_W-1:0]         acc [NCH];
  logic [CNT_W-1:0]         cnt [NCH];
  logic [ACC_W-1:0]         acc_sum;
  logic [SQ_W-1:0]          mse_val;
  logic                     win_done;
  logic                     s2_go;

  logic                     push;
  logic [E_W-1:0]           push_data;
  logic [E_W-1:0]           head;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic [FREE_W-1:0]        free;
  mse_res_t                 pop_res;
  logic                     unused_bits;

  // Two slots stay reserved for the samples that may be in flight
  // in S1 and S2, so a push never meets a full FIFO.
  assign in_ready = !clear && (free > FREE_W'(2));
  assign accept   = in_valid && in_ready;
  assign ch_ok    = int'(in_ch) < NCH;
  assign prod     = in_err * in_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_sq    <= '0;
    end else begin
      // Out-of-range channels are accepted but never enter S2.
      s1_valid <= accept && ch_ok;
      if (accept) begin
        s1_ch <= in_ch;
        s1_sq <= prod[SQ_W-1:0];
      end
    end
  end

  // S2 reads the channel state written on the previous edge, so
  // same-channel samples back to back need no forwarding.
  assign s2_go    = s1_valid && !clear;
  assign acc_sum  = acc[s1_ch] + ACC_W'(s1_sq);
  assign win_done = (cnt[s1_ch] == CNT_LAST);
  assign mse_val  = SQ_W'(acc_sum >> WIN_LOG2);
  assign push     = s2_go && win_done;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NCH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (s1_valid) begin
      if (win_done) begin
        acc[s1_ch] <= '0;
        cnt[s1_ch] <= '0;
      end else begin
        acc[s1_ch] <= acc_sum;
        cnt[s1_ch] <= cnt[s1_ch] + CNT_W'(1);
      end
    end
  end

`ifdef MSE_PEAK_EN
  logic [SQ_W-1:0] peak [NCH];
  logic [SQ_W-1:0] peak_new;

  assign peak_new =
    (s1_sq > peak[s1_ch]) ? s1_sq : peak[s1_ch];

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < NCH; i++) begin
        peak[i] <= '0;
      end
    end else if (s1_valid) begin
      peak[s1_ch] <= win_done ? '0 : peak_new;
    end
  end

  assign push_data = {s1_ch, mse_val, peak_new};
`else
  assign push_data = {s1_ch, mse_val};
`endif

  mse_result_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (E_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .free      (free)
  );

  always_comb begin
    pop_res      = '0;
    pop_res.ch   = MAX_CH_W'(head[E_W-1 -: CH_W]);
    pop_res.mse  = MAX_SQ_W'(head[E_W-CH_W-1 -: SQ_W]);
`ifdef MSE_PEAK_EN
    pop_res.peak = MAX_SQ_W'(head[SQ_W-1:0]);
`endif
  end

  assign out_valid = !fifo_empty;
  assign out_ch    = pop_res.ch[CH_W-1:0];
  assign out_mse   = pop_res.mse[SQ_W-1:0];
`ifdef MSE_PEAK_EN
  assign out_peak  = pop_res.peak[SQ_W-1:0];
`else
  assign out_peak  = '0;
`endif

  assign unused_bits = ^{pop_res, fifo_full, prod[2*DATA_W-1]};

endmodule

// File: tb/tb_mse_window_accum.sv
// tb_mse_window_accum: table-driven bench with a result
// scoreboard for mse_window_accum (WIN_LOG2 = 2).
module tb_mse_window_accum;

  localparam int DATA_W    = 18;
  localparam int NCH       = 4;
  localparam int WIN_LOG2  = 2;
  localparam int RES_DEPTH = 4;
  localparam int CH_W      = 2;
  localparam int SQ_W      = 35;

  logic                     clk       = 1'b0;
  logic                     reset     = 1'b1;
  logic                     clear     = 1'b0;
  logic                     in_valid  = 1'b0;
  logic                     out_ready = 1'b1;
  logic [CH_W-1:0]          in_ch     = '0;
  logic signed [DATA_W-1:0] in_err    = '0;
  logic                     in_ready;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic [SQ_W-1:0]          out_mse;
  logic [SQ_W-1:0]          out_peak;

  always #5 clk = ~clk;

  mse_window_accum #(
    .DATA_W    (DATA_W),
    .NCH       (NCH),
    .WIN_LOG2  (WIN_LOG2),
    .RES_DEPTH (RES_DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_err    (in_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_mse   (out_mse),
    .out_peak  (out_peak)
  );

  typedef struct {
    int     ch;
    longint mse;
    longint peak;
  } res_t;

  typedef struct {
    int     ch;
    int     err;
    bit     push;
    bit     lat;
    longint mse;
    longint peak;
  } vec_t;

  res_t sb[$];
  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic longint pk(input longint p);
`ifdef MSE_PEAK_EN
    return p;
`else
    return 0;
`endif
  endfunction

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic void add(
    input int ch, input int err, input bit push,
    input bit lat, input longint mse, input longint peak
  );
    tbl.push_back('{ch, err, push, lat, mse, peak});
  endfunction

  // Result monitor: compares the head against the scoreboard on
  // every cycle where it will be popped.
  always @(negedge clk) begin
    #2;
    if (!reset && out_valid === 1'b1 && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_result", 64'(out_valid), 64'd0);
      end else begin
        res_t r;
        r = sb.pop_front();
        check("res_ch", 64'(out_ch), 64'(r.ch));
        check("res_mse", 64'(out_mse), 64'(r.mse));
        check("res_peak", 64'(out_peak), 64'(r.peak));
      end
    end
  end

  task automatic send(input int c, input int e);
    bit rdy;
    rdy      = 1'b0;
    in_valid = 1'b1;
    in_ch    = CH_W'(c);
    in_err   = DATA_W'(e);
    for (int t = 0; t < 100; t++) begin
      #1 rdy = in_ready;
      @(negedge clk);
      if (rdy) break;
    end
    in_valid = 1'b0;
    check("send_accept", 64'(rdy), 64'd1);
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      #3;
      if (sb.size() == 0 && out_valid !== 1'b1) break;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    check("drain_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: run still active, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // basic window
    add(0, 100, 0, 0, 0, 0);
    add(0, -100, 0, 0, 0, 0);
    add(0, 200, 0, 0, 0, 0);
    add(0, -200, 1, 1, 25000, 40000);
    // extremes
    for (int i = 0; i < 4; i++)
      add(1, -131072, i == 3, 0,
          64'd17179869184, 64'd17179869184);
    for (int i = 0; i < 4; i++)
      add(1, 0, i == 3, 0, 0, 0);
    // interleave
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        add(c, 10 * (c + 1), r == 3, 0,
            100 * (c + 1) * (c + 1),
            100 * (c + 1) * (c + 1));

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_ch", 64'(out_ch), 64'd0);
    check("rst_out_mse", 64'(out_mse), 64'd0);
    check("rst_out_peak", 64'(out_peak), 64'd0);
    @(negedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].push)
        sb.push_back('{tbl[i].ch, tbl[i].mse,
                       pk(tbl[i].peak)});
      send(tbl[i].ch, tbl[i].err);
      if (tbl[i].lat) begin
        #1 check("lat_e0", 64'(out_valid), 64'd0);
        @(negedge clk);
        #1 check("lat_e1", 64'(out_valid), 64'd1);
      end
    end
    wait_drain();

    // backpressure: two windows on ch2 held in the FIFO
    @(negedge clk);
    out_ready = 1'b0;
    sb.push_back('{2, 9, pk(9)});
    repeat (4) send(2, 3);
    sb.push_back('{2, 25, pk(25)});
    repeat (4) send(2, 5);
    @(negedge clk);
    #1 check("bp_ready_low", 64'(in_ready), 64'd0);
    repeat (3) @(negedge clk);
    #1;
    check("bp_ready_hold", 64'(in_ready), 64'd0);
    check("bp_valid", 64'(out_valid), 64'd1);
    check("bp_head_ch", 64'(out_ch), 64'd2);
    check("bp_head_mse", 64'(out_mse), 64'd9);
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();
    check("bp_ready_high", 64'(in_ready), 64'd1);

    // clear mid-window
    @(negedge clk);
    repeat (3) send(3, 50);
    clear = 1'b1;
    #1 check("clr_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    clear = 1'b0;
    sb.push_back('{3, 49, pk(49)});
    repeat (4) send(3, 7);
    wait_drain();

    // reset mid-window, with a held result that must vanish
    @(negedge clk);
    out_ready = 1'b0;
    repeat (4) send(0, 1);
    @(negedge clk);
    #1 check("held_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    repeat (3) send(3, 50);
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1 check("rst_valid_low", 64'(out_valid), 64'd0);
    end
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst2_mse", 64'(out_mse), 64'd0);
    check("rst2_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    sb.push_back('{3, 49, pk(49)});
    repeat (4) send(3, 7);
    wait_drain();

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_miss);
    $finish;
  end

endmodule
